// File: rtl/eight_way_grant_arbiter_pkg.sv
// Shared definitions for the eight-way round-robin grant arbiter.
// Contents: requester count, index width, hold counter width, FSM state enum,
// and the round-robin winner search function.
package eight_way_grant_arbiter_pkg;

    localparam int unsigned NREQ  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set request bit searching ptr+1, ptr+2, ... modulo NREQ.
    // The ptr slot itself is the last candidate. Returns ptr when req is empty.
    function automatic logic [IDX_W-1:0] rr_next(input logic [NREQ-1:0]  req,
                                                  input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] cand;
        logic             found;
        rr_next = ptr;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDX_W'(ptr + IDX_W'(k));
            if (!found && req[cand]) begin
                rr_next = cand;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/eight_way_grant_arbiter_line_decoder.sv
// 3-to-8 line decoder with enable.
// Ports: i_idx (3-bit index), i_en (enable), o_onehot_c (one-hot, zero when disabled).
module line_decoder_3to8
    import eight_way_grant_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [NREQ-1:0]  o_onehot_c
);

    always_comb begin
        o_onehot_c = '0;
        if (i_en) begin
            o_onehot_c[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/eight_way_grant_arbiter.sv
// Round-robin arbiter sharing one resource among eight requesters with a
// request/done handshake and a one-cycle idle gap between owners.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after TIMEOUT cycles).
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   req[7:0]       - level-sensitive request vector
//   done           - owner ends its grant (ignored while idle)
//   grant_idx[2:0] - registered owner index
//   grant_en       - registered grant-active flag
//   grant[7:0]     - one-hot decode of grant_idx gated by grant_en
//   busy           - copy of grant_en
//   timeout        - one-cycle pulse on forced release
module eight_way_grant_arbiter
    import eight_way_grant_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_en,
    output logic [NREQ-1:0]  grant,
    output logic             busy,
    output logic             timeout
);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_ptr;
    logic             r_grant_en;

    logic [IDX_W-1:0] w_winner;
    logic             w_release;
    logic             w_hold_expired;

    assign w_winner  = rr_next(req, r_ptr);
    // Owner-driven release: explicit done or the owner withdrawing its request.
    assign w_release = done | ~req[r_grant_idx];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout;

    assign w_hold_expired = (r_hold_cnt == CNT_W'(TIMEOUT - 1));

    // Hold counter sits at zero while idle, so it starts at zero on grant entry.
    // The timeout pulse is suppressed when an owner release lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= (r_state == GRANT) && !w_release && w_hold_expired;
            if (r_state == GRANT) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_hold_expired   = 1'b0;
    assign timeout          = 1'b0;
`endif

    // Arbitration FSM; ptr advances only when a new grant is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
            r_grant_en  <= 1'b0;
            r_ptr       <= IDX_W'(NREQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_grant_idx <= w_winner;
                        r_ptr       <= w_winner;
                        r_grant_en  <= 1'b1;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_release || w_hold_expired) begin
                        r_grant_en <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_grant_en <= 1'b0;
                end
            endcase
        end
    end

    line_decoder_3to8 u_decoder (
        .i_idx      (r_grant_idx),
        .i_en       (r_grant_en),
        .o_onehot_c (grant)
    );

    assign grant_idx = r_grant_idx;
    assign grant_en  = r_grant_en;
    assign busy      = r_grant_en;

endmodule

// File: tb/tb_eight_way_grant_arbiter.sv
// Self-checking bench for eight_way_grant_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural round-robin model.
module tb_eight_way_grant_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [2:0] grant_idx;
    logic       grant_en;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;

    int checks;
    int failures;

    // Behavioural model state
    bit m_busy;
    bit m_to;
    int m_idx;
    int m_ptr;
    int m_cnt;

    eight_way_grant_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant_idx (grant_idx),
        .grant_en  (grant_en),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] exp_vec();
        logic [7:0] g;
        g = m_busy ? 8'(1 << m_idx) : 8'h00;
        return {3'(m_idx), m_busy, g, m_busy, m_to};
    endfunction

    // Advance the model by one clock using the current inputs.
    task model_step();
        int w;
        if (rst) begin
            m_busy = 0; m_to = 0; m_idx = 0; m_ptr = 7; m_cnt = 0;
        end else if (!m_busy) begin
            m_to = 0;
            if (req != 8'h00) begin
                w = -1;
                for (int k = 1; k <= 8; k++)
                    if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
                m_idx = w; m_ptr = w; m_busy = 1; m_cnt = 0;
            end
        end else begin
            if (done || !req[m_idx]) begin
                m_busy = 0; m_to = 0;
            end else if (TO_EN && m_cnt == TO - 1) begin
                m_busy = 0; m_to = 1;
            end else begin
                m_cnt++; m_to = 0;
            end
        end
    endtask

    task cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task do_reset();
        rst = 1; req = 8'h00; done = 0;
        cyc();
        rst = 0;
    endtask

    task test_reset();
        rst = 1; req = 8'hFF; done = 1;
        cyc(); cyc();
        checks++;
        if ({grant_idx, grant_en, grant, busy, timeout} !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {grant_idx, grant_en, grant, busy, timeout}, 14'h0);
        end
        rst = 0; req = 8'h00; done = 0;
        cyc();
        checks++;
        if (grant_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_hold: grant_en got %b expected 0", grant_en);
        end
    endtask

    task test_first_grant();
        do_reset();
        req = 8'h01;
        cyc();
        checks++;
        if (grant_idx !== 3'd0 || grant !== 8'h01 || grant_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL first_grant: idx=%0d grant=%h en=%b busy=%b expected 0/01/1/1",
                     grant_idx, grant, grant_en, busy);
        end
        done = 1;
        cyc();
        done = 0; req = 8'h00;
        checks++;
        if (grant !== 8'h00 || grant_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL first_release: grant=%h en=%b expected 00/0", grant, grant_en);
        end
        cyc();
    endtask

    task test_rotation();
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            cyc();
            checks++;
            if (grant_en !== 1'b1 || grant_idx !== 3'(i % 8) || grant !== 8'(1 << (i % 8))) begin
                failures++;
                $display("FAIL rotation_grant[%0d]: en=%b idx=%0d grant=%h expected 1/%0d/%h",
                         i, grant_en, grant_idx, grant, i % 8, 8'(1 << (i % 8)));
            end
            done = 1;
            cyc();
            done = 0;
            checks++;
            if (grant_en !== 1'b0 || grant !== 8'h00) begin
                failures++;
                $display("FAIL rotation_gap[%0d]: en=%b grant=%h expected 0/00", i, grant_en, grant);
            end
        end
        req = 8'h00;
        cyc();
    endtask

    task test_ptr_skip();
        do_reset();
        req = 8'h04;
        cyc();
        checks++;
        if (grant_idx !== 3'd2 || grant_en !== 1'b1) begin
            failures++;
            $display("FAIL skip_first: idx=%0d en=%b expected 2/1", grant_idx, grant_en);
        end
        req = 8'h24; done = 1;
        cyc();
        done = 0;
        cyc();
        checks++;
        if (grant_idx !== 3'd5 || grant !== 8'h20) begin
            failures++;
            $display("FAIL skip_second: idx=%0d grant=%h expected 5/20", grant_idx, grant);
        end
        done = 1;
        cyc();
        done = 0;
        cyc();
        checks++;
        if (grant_idx !== 3'd2 || grant !== 8'h04) begin
            failures++;
            $display("FAIL skip_third: idx=%0d grant=%h expected 2/04", grant_idx, grant);
        end
        req = 8'h00; done = 1;
        cyc();
        done = 0;
        cyc();
    endtask

    task test_owner_drop();
        do_reset();
        req = 8'h88;
        cyc();
        checks++;
        if (grant_idx !== 3'd3 || grant_en !== 1'b1) begin
            failures++;
            $display("FAIL drop_grant3: idx=%0d en=%b expected 3/1", grant_idx, grant_en);
        end
        req = 8'h80;
        cyc();
        checks++;
        if (grant_en !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL drop_release: en=%b timeout=%b expected 0/0", grant_en, timeout);
        end
        cyc();
        checks++;
        if (grant_idx !== 3'd7 || grant !== 8'h80) begin
            failures++;
            $display("FAIL drop_next: idx=%0d grant=%h expected 7/80", grant_idx, grant);
        end
        req = 8'h00;
        cyc();
        cyc();
    endtask

    task test_timeout();
        int n;
        do_reset();
        req = 8'h02;
        cyc();
        checks++;
        if (grant_idx !== 3'd1 || grant_en !== 1'b1) begin
            failures++;
            $display("FAIL hold_grant: idx=%0d en=%b expected 1/1", grant_idx, grant_en);
        end
`ifdef ARB_TIMEOUT_EN
        n = 1;
        for (int j = 0; j < 20; j++) begin
            cyc();
            if (grant_en !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != TO || timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_len: held=%0d timeout=%b expected %0d/1", n, timeout, TO);
        end
        cyc();
        checks++;
        if (grant_en !== 1'b1 || grant_idx !== 3'd1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_regrant: en=%b idx=%0d timeout=%b expected 1/1/0",
                     grant_en, grant_idx, timeout);
        end
        // done coinciding with the expiry cycle is a normal release
        cyc(); cyc(); cyc();
        done = 1;
        cyc();
        done = 0;
        checks++;
        if (grant_en !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_done_same: en=%b timeout=%b expected 0/0", grant_en, timeout);
        end
`else
        n = 0;
        for (int j = 0; j < 40; j++) begin
            cyc();
            if (grant_en === 1'b1 && timeout === 1'b0) n++;
        end
        checks++;
        if (n != 40) begin
            failures++;
            $display("FAIL hold_forever: held cycles=%0d expected 40", n);
        end
`endif
        req = 8'h00; done = 1;
        cyc();
        done = 0;
        cyc();
    endtask

    task test_reset_mid_grant();
        do_reset();
        req = 8'h40;
        cyc();
        checks++;
        if (grant_idx !== 3'd6 || grant_en !== 1'b1) begin
            failures++;
            $display("FAIL midrst_grant6: idx=%0d en=%b expected 6/1", grant_idx, grant_en);
        end
        req = 8'hC1; rst = 1;
        cyc();
        checks++;
        if ({grant_idx, grant_en, grant, busy, timeout} !== 14'h0) begin
            failures++;
            $display("FAIL midrst_clear: got %h expected %h",
                     {grant_idx, grant_en, grant, busy, timeout}, 14'h0);
        end
        rst = 0;
        cyc();
        checks++;
        if (grant_idx !== 3'd0 || grant !== 8'h01) begin
            failures++;
            $display("FAIL midrst_first: idx=%0d grant=%h expected 0/01", grant_idx, grant);
        end
        req = 8'h00; done = 1;
        cyc();
        done = 0;
    endtask

    task test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 49) == 0);
            cyc();
            checks++;
            if ({grant_idx, grant_en, grant, busy, timeout} !== exp_vec()) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: got %h expected %h", i,
                             {grant_idx, grant_en, grant, busy, timeout}, exp_vec());
            end
        end
        rst = 0; req = 8'h00; done = 0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1; req = 8'h00; done = 0;
        m_busy = 0; m_to = 0; m_idx = 0; m_ptr = 7; m_cnt = 0;
        test_reset();
        test_first_grant();
        test_rotation();
        test_ptr_skip();
        test_owner_drop();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eight_way_grant_arbiter.md
# eight_way_grant_arbiter

Round-robin arbiter that shares one 8-way resource among eight requesters. It selects one requester at a time and drives a registered 3-bit index plus enable. A 3-to-8 line decoder turns these into a one-hot grant vector. The block sits between the requesting agents and the shared resource's select/enable lines, and sequences ownership with a request/done handshake.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles one grant may be held, counted from the first cycle `grant_en`=1. Legal range 2..255. Used only when `ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  8  request vector; bit k = requester k. Level-sensitive.
- `done`  input  1  pulse from the current owner ending its grant. Ignored unless `grant_en`=1.
- `grant_idx`  output  3  registered index of the current owner.
- `grant_en`  output  1  registered; 1 while a grant is active.
- `grant`  output  8  one-hot decode of `grant_idx` gated by `grant_en`. All zero when `grant_en`=0.
- `busy`  output  1  equals `grant_en`. Kept as a separate port for resource-side logic.
- `timeout`  output  1  one-cycle pulse when a grant is force-revoked.

## Operation
- States: IDLE, GRANT.
- Reset values:
  - state = IDLE
  - `grant_idx`=0, `grant_en`=0, `grant`=0, `busy`=0, `timeout`=0
  - rotation pointer `ptr`=7, so requester 0 wins first
  - hold counter = 0
- IDLE:
  - If `req`≠0, pick the first set bit searching `ptr+1`, `ptr+2`, … modulo 8, wrapping 7→0.
  - Register the winner into `grant_idx` and `ptr`, set `grant_en`=1, go to GRANT.
  - If `req`=0, stay in IDLE with all outputs held.
- GRANT: release when either condition holds:
  - `done`=1, or
  - `req[grant_idx]`=0 (owner withdrew).
- On release:
  - `grant_en`←0 and go to IDLE.
  - `grant_idx` holds its value; `grant` goes to 0.
  - Re-arbitration happens in IDLE on the following cycle, giving a minimum one-cycle gap between owners.
- `ptr` updates only on a new grant, never on release. Fairness: a continuously requesting agent waits at most 7 grants.
- Simultaneous `done` and owner `req` drop: a single release with no extra effect.
- Requests arriving during GRANT are held off until IDLE.
- `grant` comes from a combinational decode of the registered `grant_idx` and `grant_en`, so it is glitch-free relative to `clk`.

## Timing
- Request to grant: `req` sampled high in IDLE at edge N → `grant_en`=1 and `grant` valid after edge N.
- Release: `done` sampled at edge M → `grant_en`=0 after edge M.
- Back-to-back: the next owner's `grant_en` rises after edge M+1.
- Reset is synchronous and dominates all other inputs. `rst` high at an edge during GRANT → `grant_en`=0 and `ptr`=7 after that edge. No `timeout` pulse is produced.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- With the macro defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches `TIMEOUT`-1 with no release, the grant is force-released, same as a release on `done`.
  - `timeout` pulses high for the one cycle in which `grant_en` falls.
  - If `done` arrives in the same cycle as the timeout, it is a normal release and `timeout` stays 0.
- Without the macro: no counter is built, `timeout` is tied to 0, and grants are held indefinitely.

## Structure
- Package `eight_way_grant_arbiter_pkg`:
  - `NREQ`=8, `IDX_W`=3
  - state enum (IDLE, GRANT)
  - round-robin next-index function
- One sub-module, `line_decoder_3to8`: inputs are the 3-bit index and an enable; output is an 8-bit one-hot vector. It is instantiated once to form `grant`.

## Test plan
- Reset, then `req`=0x01 → after the next edge `grant_idx`=0, `grant`=0x01. Pulse `done` → `grant`=0x00 one edge later.
- `req`=0xFF held, `done` pulsed one cycle after each grant → grant order 0,1,2,…,7,0. Each grant is separated by exactly one idle cycle.
- After a grant to 2 (`ptr`=2), `req`=0x24 → next grant is 5, then 2. Bit 2 is not regranted first.
- Owner 3 drops `req[3]` mid-grant while `req`=0x88 → `grant_en` falls after that edge; the next grant is 7.
- `ARB_TIMEOUT_EN` defined, `TIMEOUT`=4, `req`=0x02, no `done` → `grant_en` high for exactly 4 cycles. `timeout` pulses once as it falls; the bit-1 regrant follows after one idle cycle.
- `rst` asserted during a grant to 6 with `req`=0xC1 → outputs cleared after that edge. After `rst` drops, the first grant is 0.
